pipe_stage_skid: RTL and testbench

//  Generic parametrised pipeline stage register. It supersedes the per-stage

---
 rtl/pipe_stage_skid_pkg.sv | 13 +
 rtl/pipe_stage_skid_sat_counter.sv | 34 +++
 rtl/pipe_stage_skid.sv | 137 +++++++++++++
 tb/tb_pipe_stage_skid.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_stage_skid_pkg.sv
// Shared types for the generic pipeline stage register: FSM state encoding
// and the default perf counter width.
package pipe_stage_skid_pkg;

  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_ONE   = 2'd1,
    PS_TWO   = 2'd2
  } pstage_t;

  localparam int PERF_CNTW = 16;

endpackage

// File: rtl/pipe_stage_skid_sat_counter.sv
// Saturating up-counter for perf events; a clear beats an increment in the
// same cycle and the count sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         nRST,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Generic valid/ready pipeline stage with stall, flush, optional 2-entry skid
// buffer (registered in_ready) and saturating stall/flush event counters.
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int DW   = 128,
  parameter bit SKID = 1'b1,
  parameter int CNTW = PERF_CNTW
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [DW-1:0]   in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   out_data,
  input  logic            stall,
  input  logic            flush,
  input  logic            cnt_clr,
  output logic [CNTW-1:0] stall_cnt,
  output logic [CNTW-1:0] flush_cnt
);

  pstage_t       state_q, state_d;
  logic [DW-1:0] main_q, main_d;
  logic [DW-1:0] skid_q, skid_d;
  logic          main_v_q, main_v_d;
  logic          skid_v_q, skid_v_d;
  logic          in_ready_c;
  logic          in_fire;
  logic          out_fire;
  logic          stall_inc;
  logic          flush_inc;

  // With the skid buffer, in_ready depends only on flops and the hazard
  // inputs, never on out_ready.
  always_comb begin
    if (SKID) begin
      in_ready_c = ~skid_v_q & ~stall & ~flush;
    end else begin
      in_ready_c = (~main_v_q | out_ready) & ~stall & ~flush;
    end
  end

  assign out_fire = main_v_q & out_ready & ~stall;
  assign in_fire  = in_valid & in_ready_c;

  always_comb begin
    state_d  = state_q;
    main_d   = main_q;
    main_v_d = main_v_q;
    skid_d   = skid_q;
    skid_v_d = skid_v_q;
    if (flush) begin
      state_d  = PS_EMPTY;
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else begin
      case (state_q)
        PS_EMPTY: begin
          if (in_fire) begin
            state_d  = PS_ONE;
            main_d   = in_data;
            main_v_d = 1'b1;
          end
        end
        PS_ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (in_fire && SKID) begin
            state_d  = PS_TWO;
            skid_d   = in_data;
            skid_v_d = 1'b1;
          end else if (out_fire) begin
            state_d  = PS_EMPTY;
            main_v_d = 1'b0;
          end
        end
        PS_TWO: begin
          if (out_fire) begin
            state_d  = PS_ONE;
            main_d   = skid_q;
            skid_v_d = 1'b0;
          end
        end
        default: begin
          state_d  = PS_EMPTY;
          main_v_d = 1'b0;
          skid_v_d = 1'b0;
        end
      endcase
    end
  end

  // In the SKID=0 build skid_d never leaves its reset value, so the skid
  // flops are constant and drop out of the netlist.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= PS_EMPTY;
      main_q   <= '0;
      main_v_q <= 1'b0;
      skid_q   <= '0;
      skid_v_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      main_q   <= main_d;
      main_v_q <= main_v_d;
      skid_q   <= skid_d;
      skid_v_q <= skid_v_d;
    end
  end

  assign in_ready  = in_ready_c;
  assign out_valid = main_v_q;
  assign out_data  = main_q;

  assign stall_inc = main_v_q & ~out_fire & ~flush;
  assign flush_inc = flush & (main_v_q | skid_v_q);

  sat_counter #(.W(CNTW)) u_stall_cnt (
    .CLK  (CLK),
    .nRST (nRST),
    .inc  (stall_inc),
    .clr  (cnt_clr),
    .q    (stall_cnt)
  );

  sat_counter #(.W(CNTW)) u_flush_cnt (
    .CLK  (CLK),
    .nRST (nRST),
    .inc  (flush_inc),
    .clr  (cnt_clr),
    .q    (flush_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: three builds (skid/128b, skid/CNTW=4, no-skid)
// share one stimulus stream and are compared against a small FIFO model.
module tb_pipe_stage_skid;
  import pipe_stage_skid_pkg::*;

  logic         CLK = 1'b0;
  logic         nRST = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic         stall = 1'b0;
  logic         flush = 1'b0;
  logic         cnt_clr = 1'b0;
  logic [127:0] in_data = '0;

  logic         a_in_ready, a_out_valid;
  logic [127:0] a_out_data;
  logic [15:0]  a_stall_cnt, a_flush_cnt;
  logic         b_in_ready, b_out_valid;
  logic [7:0]   b_out_data;
  logic [3:0]   b_stall_cnt, b_flush_cnt;
  logic         c_in_ready, c_out_valid;
  logic [7:0]   c_out_data;
  logic [15:0]  c_stall_cnt, c_flush_cnt;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  pipe_stage_skid #(.DW(128), .SKID(1'b1), .CNTW(16)) u_a (
    .CLK(CLK), .nRST(nRST), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_data(in_data), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_data(a_out_data), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
    .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
  );

  pipe_stage_skid #(.DW(8), .SKID(1'b1), .CNTW(4)) u_b (
    .CLK(CLK), .nRST(nRST), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_data(in_data[7:0]), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_data(b_out_data), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
    .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
  );

  pipe_stage_skid #(.DW(8), .SKID(1'b0), .CNTW(16)) u_c (
    .CLK(CLK), .nRST(nRST), .in_valid(in_valid), .in_ready(c_in_ready),
    .in_data(in_data[7:0]), .out_valid(c_out_valid), .out_ready(out_ready),
    .out_data(c_out_data), .stall(stall), .flush(flush), .cnt_clr(cnt_clr),
    .stall_cnt(c_stall_cnt), .flush_cnt(c_flush_cnt)
  );

  logic         rdy [3];
  logic         vld [3];
  logic [127:0] dat [3];
  logic [15:0]  sc  [3];
  logic [15:0]  fc  [3];

  assign rdy[0] = a_in_ready;
  assign rdy[1] = b_in_ready;
  assign rdy[2] = c_in_ready;
  assign vld[0] = a_out_valid;
  assign vld[1] = b_out_valid;
  assign vld[2] = c_out_valid;
  assign dat[0] = a_out_data;
  assign dat[1] = {120'd0, b_out_data};
  assign dat[2] = {120'd0, c_out_data};
  assign sc[0]  = a_stall_cnt;
  assign sc[1]  = {12'd0, b_stall_cnt};
  assign sc[2]  = c_stall_cnt;
  assign fc[0]  = a_flush_cnt;
  assign fc[1]  = {12'd0, b_flush_cnt};
  assign fc[2]  = c_flush_cnt;

  // Reference model: each build is a FIFO of capacity 2 (skid) or 1 (no skid)
  // plus two saturating event counts.
  logic [127:0] mbuf [3][2];
  int           mcnt [3];
  int           mst  [3];
  int           mfl  [3];

  function automatic int cap(input int i);
    return (i < 2) ? 2 : 1;
  endfunction

  function automatic int cmax(input int i);
    return (i == 1) ? 15 : 65535;
  endfunction

  function automatic logic m_ready(input int i);
    if (stall || flush) return 1'b0;
    if (cap(i) == 2) return (mcnt[i] < 2);
    return (mcnt[i] == 0) || out_ready;
  endfunction

  always @(posedge CLK or negedge nRST) begin : model
    logic         ofire;
    logic         ifire;
    logic [127:0] d;
    if (!nRST) begin
      for (int i = 0; i < 3; i++) begin
        mcnt[i] = 0;
        mst[i]  = 0;
        mfl[i]  = 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        ofire = (mcnt[i] > 0) && out_ready && !stall;
        ifire = in_valid && m_ready(i);
        d = (i == 0) ? in_data : {120'd0, in_data[7:0]};
        if (cnt_clr) mst[i] = 0;
        else if ((mcnt[i] > 0) && !ofire && !flush && (mst[i] < cmax(i))) mst[i]++;
        if (cnt_clr) mfl[i] = 0;
        else if (flush && (mcnt[i] > 0) && (mfl[i] < cmax(i))) mfl[i]++;
        if (flush) begin
          mcnt[i] = 0;
        end else begin
          if (ofire) begin
            mbuf[i][0] = mbuf[i][1];
            mcnt[i]--;
          end
          if (ifire) begin
            mbuf[i][mcnt[i]] = d;
            mcnt[i]++;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; out_ready = 1'b0; stall = 1'b0; flush = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    nRST = 1'b0;
    repeat (2) @(negedge CLK);
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", a_out_valid); end
    checks++; if (a_out_data !== 128'd0) begin errors++; $display("FAIL reset_out_data got %0h want 0", a_out_data); end
    checks++; if (a_stall_cnt !== 16'd0 || a_flush_cnt !== 16'd0) begin errors++; $display("FAIL reset_counters got %0d/%0d want 0/0", a_stall_cnt, a_flush_cnt); end
    checks++; if (c_out_valid !== 1'b0 || b_out_valid !== 1'b0) begin errors++; $display("FAIL reset_other_valid got %0b/%0b want 0/0", b_out_valid, c_out_valid); end
    nRST = 1'b1;
    tick();
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b want 1", a_in_ready); end
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      in_valid = 1'b1;
      in_data  = 128'(k);
      tick();
      checks++; if (a_out_valid !== 1'b1 || a_out_data !== 128'(k)) begin errors++; $display("FAIL stream_out[%0d] got v=%0b d=%0h want v=1 d=%0h", k, a_out_valid, a_out_data, k); end
      checks++; if (u_a.state_q !== PS_ONE || a_in_ready !== 1'b1) begin errors++; $display("FAIL stream_state[%0d] got %0d rdy=%0b want ONE rdy=1", k, u_a.state_q, a_in_ready); end
      checks++; if (c_out_data !== 8'(k)) begin errors++; $display("FAIL stream_c_out[%0d] got %0h want %0h", k, c_out_data, k); end
    end
    checks++; if (a_stall_cnt !== 16'd0) begin errors++; $display("FAIL stream_stall_cnt got %0d want 0", a_stall_cnt); end
    in_valid = 1'b0;
    tick();
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain got %0b want 0", a_out_valid); end
  endtask

  task automatic test_backpressure();
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    out_ready = 1'b0; in_valid = 1'b1; in_data = 128'hA;
    tick();
    checks++; if (a_out_data !== 128'hA || a_in_ready !== 1'b1) begin errors++; $display("FAIL bp_first got d=%0h rdy=%0b want d=a rdy=1", a_out_data, a_in_ready); end
    in_data = 128'hB;
    tick();
    checks++; if (u_a.state_q !== PS_TWO || a_in_ready !== 1'b0) begin errors++; $display("FAIL bp_two got st=%0d rdy=%0b want TWO rdy=0", u_a.state_q, a_in_ready); end
    in_valid = 1'b0;
    tick();
    checks++; if (a_stall_cnt !== 16'd2) begin errors++; $display("FAIL bp_stall_cnt got %0d want 2", a_stall_cnt); end
    checks++; if (a_out_data !== 128'hA) begin errors++; $display("FAIL bp_hold got %0h want a", a_out_data); end
    out_ready = 1'b1;
    tick();
    checks++; if (a_out_valid !== 1'b1 || a_out_data !== 128'hB) begin errors++; $display("FAIL bp_order got v=%0b d=%0h want v=1 d=b", a_out_valid, a_out_data); end
    tick();
    checks++; if (a_out_valid !== 1'b0 || a_stall_cnt !== 16'd2) begin errors++; $display("FAIL bp_done got v=%0b cnt=%0d want v=0 cnt=2", a_out_valid, a_stall_cnt); end
  endtask

  task automatic test_stall_flush();
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    out_ready = 1'b0; in_valid = 1'b1; in_data = 128'h11;
    tick();
    in_data = 128'h22;
    tick();
    in_valid = 1'b0; stall = 1'b1; out_ready = 1'b1;
    #1;
    checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready got %0b want 0", a_in_ready); end
    tick();
    checks++; if (a_out_valid !== 1'b1 || a_out_data !== 128'h11 || u_a.state_q !== PS_TWO) begin errors++; $display("FAIL stall_frozen got v=%0b d=%0h st=%0d want v=1 d=11 TWO", a_out_valid, a_out_data, u_a.state_q); end
    checks++; if (a_stall_cnt !== 16'd2) begin errors++; $display("FAIL stall_cnt got %0d want 2", a_stall_cnt); end
    flush = 1'b1;
    tick();
    checks++; if (a_out_valid !== 1'b0 || u_a.state_q !== PS_EMPTY) begin errors++; $display("FAIL flush_empty got v=%0b st=%0d want v=0 EMPTY", a_out_valid, u_a.state_q); end
    checks++; if (a_flush_cnt !== 16'd1 || a_stall_cnt !== 16'd2) begin errors++; $display("FAIL flush_cnts got f=%0d s=%0d want f=1 s=2", a_flush_cnt, a_stall_cnt); end
    tick();
    checks++; if (a_flush_cnt !== 16'd1) begin errors++; $display("FAIL flush_empty_nocount got %0d want 1", a_flush_cnt); end
    idle_inputs();
    tick();
  endtask

  task automatic test_saturation();
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    out_ready = 1'b0; in_valid = 1'b1; in_data = 128'h5;
    tick();
    in_valid = 1'b0;
    repeat (20) tick();
    checks++; if (b_stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_b got %0d want 15", b_stall_cnt); end
    checks++; if (a_stall_cnt !== 16'd20) begin errors++; $display("FAIL sat_a got %0d want 20", a_stall_cnt); end
    cnt_clr = 1'b1;
    tick();
    checks++; if (b_stall_cnt !== 4'd0 || a_stall_cnt !== 16'd0) begin errors++; $display("FAIL sat_clr got %0d/%0d want 0/0", b_stall_cnt, a_stall_cnt); end
    cnt_clr = 1'b0; flush = 1'b1;
    tick();
    idle_inputs();
    tick();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 128'h33;
    tick();
    in_data = 128'h44;
    tick();
    in_valid = 1'b0;
    @(posedge CLK);
    #2 nRST = 1'b0;
    #1;
    checks++; if (a_out_valid !== 1'b0 || u_a.state_q !== PS_EMPTY) begin errors++; $display("FAIL async_rst_valid got v=%0b st=%0d want v=0 EMPTY", a_out_valid, u_a.state_q); end
    checks++; if (a_stall_cnt !== 16'd0 || a_flush_cnt !== 16'd0) begin errors++; $display("FAIL async_rst_cnt got %0d/%0d want 0/0", a_stall_cnt, a_flush_cnt); end
    @(negedge CLK);
    nRST = 1'b1;
    idle_inputs();
    tick();
  endtask

  task automatic test_skid0();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 128'h61;
    tick();
    #1;
    checks++; if (c_in_ready !== 1'b0) begin errors++; $display("FAIL skid0_block got %0b want 0", c_in_ready); end
    out_ready = 1'b1;
    #1;
    checks++; if (c_in_ready !== 1'b1) begin errors++; $display("FAIL skid0_open got %0b want 1", c_in_ready); end
    for (int k = 0; k < 6; k++) begin
      in_data = 128'(8'h70 + k);
      tick();
      checks++; if (c_out_valid !== 1'b1 || c_out_data !== 8'(8'h70 + k)) begin errors++; $display("FAIL skid0_pass[%0d] got v=%0b d=%0h want v=1 d=%0h", k, c_out_valid, c_out_data, 8'h70 + k); end
    end
    idle_inputs();
    out_ready = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      stall     = ($urandom_range(0, 9) == 0);
      flush     = ($urandom_range(0, 24) == 0);
      cnt_clr   = ($urandom_range(0, 59) == 0);
      in_data   = {$urandom, $urandom, $urandom, $urandom};
      #1;
      for (int i = 0; i < 3; i++) begin
        checks++; if (rdy[i] !== m_ready(i)) begin errors++; $display("FAIL rnd_in_ready[%0d] cyc %0d got %0b want %0b", i, n, rdy[i], m_ready(i)); end
      end
      tick();
      for (int i = 0; i < 3; i++) begin
        checks++; if (vld[i] !== (mcnt[i] > 0)) begin errors++; $display("FAIL rnd_out_valid[%0d] cyc %0d got %0b want %0b", i, n, vld[i], mcnt[i] > 0); end
        if (mcnt[i] > 0) begin
          checks++; if (dat[i] !== mbuf[i][0]) begin errors++; $display("FAIL rnd_out_data[%0d] cyc %0d got %0h want %0h", i, n, dat[i], mbuf[i][0]); end
        end
        checks++; if (sc[i] !== 16'(mst[i]) || fc[i] !== 16'(mfl[i])) begin errors++; $display("FAIL rnd_cnt[%0d] cyc %0d got %0d/%0d want %0d/%0d", i, n, sc[i], fc[i], mst[i], mfl[i]); end
      end
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_stall_flush();
    test_saturation();
    test_async_reset();
    test_skid0();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
